// File: rtl/proyecto_if.sv
// ---------------------------------------------------------------------------
// proyecto_if -- processor / data-memory bus seen by the framebuffer block.
//
// Signals:
//   ALUResult  processor byte address (direct framebuffer writes)
//   RD2        processor store data, [7:0] = RGB332 colour
//   MemWrite   processor store strobe
//   END        processor-finished flag (level)
//   ReadData   data memory output for ADDRES, same-cycle
//   ADDRES     address driven to data memory by the framebuffer block
//
// Modports:
//   master  processor + data memory side (drives everything but ADDRES)
//   slave   framebuffer/VGA block (drives ADDRES only)
// ---------------------------------------------------------------------------
interface proyecto_if;
    logic [31:0] ALUResult;
    logic [31:0] RD2;
    logic        MemWrite;
    logic        END;
    logic [31:0] ReadData;
    logic [31:0] ADDRES;

    modport master (output ALUResult, RD2, MemWrite, END, ReadData, input ADDRES);
    modport slave  (input  ALUResult, RD2, MemWrite, END, ReadData, output ADDRES);
endinterface

// File: rtl/proyecto.sv
// ---------------------------------------------------------------------------
// proyecto -- 80x60 cell framebuffer (8x8 pixel cells, RGB332) with a
// 640x480@60 VGA scan-out.
//
// While the processor runs, stores that land in the framebuffer window are
// written straight into the framebuffer. Once the processor raises END, the
// block copies 4800 words from data memory (starting at MEM_BASE) into the
// framebuffer, one word per clock, then parks in DONE until reset.
//
// Parameters:
//   MEM_BASE  byte address of the first source word of the copy
//   FB_BASE   byte address of framebuffer cell 0 in the direct-write window
//
// Ports:
//   CLOCK2_50        50 MHz clock, everything on the rising edge
//   KEY              synchronous active-high reset
//   bus              processor/memory bus (proyecto_if.slave)
//   VGA_CLK          25 MHz pixel clock (pixel-enable toggle register)
//   VGA_HS, VGA_VS   active-low syncs
//   VGA_SYNC_N       tied 0
//   VGA_BLANK_N      1 inside the visible 640x480 area
//   VGA_R/G/B        8-bit colour channels, expanded from RGB332
//
// Build option:
//   PROYECTO_BORDER_EN  when defined, the outermost visible ring of pixels
//                       (h=0, h=639, v=0, v=479) is forced to white.
// ---------------------------------------------------------------------------
module proyecto #(
    parameter logic [31:0] MEM_BASE = 32'h0000_1000,
    parameter logic [31:0] FB_BASE  = 32'h0000_2000
) (
    input  logic       CLOCK2_50,
    input  logic       KEY,
    proyecto_if.slave  bus,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_SYNC_N,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int          FB_CELLS = 4800;
    localparam logic [12:0] LAST_IDX = 13'd4799;
    // Last word-aligned byte address that still maps onto a cell.
    localparam logic [31:0] FB_LAST  = FB_BASE + 32'd19196;

    // Horizontal / vertical timing, in pixels / lines.
    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_SYNC0 = 10'd656;
    localparam logic [9:0] H_SYNC1 = 10'd751;
    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_SYNC0 = 10'd490;
    localparam logic [9:0] V_SYNC1 = 10'd491;
    localparam logic [9:0] V_LAST  = 10'd524;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Control FSM and copy counter
    // -----------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [12:0] r_cnt, w_cnt_nxt;

    logic        w_in_win;
    logic [31:0] w_dw_off;
    logic [12:0] w_dw_idx;

    logic        w_fb_we;
    logic [12:0] w_fb_waddr;
    logic [7:0]  w_fb_wdata;
    logic [31:0] w_addres;

    logic [7:0]  r_fb [0:FB_CELLS-1];

    // Direct-write window decode; the byte offset inside a word is dropped.
    assign w_in_win = (bus.ALUResult >= FB_BASE) && (bus.ALUResult <= FB_LAST);
    assign w_dw_off = bus.ALUResult - FB_BASE;
    assign w_dw_idx = w_dw_off[14:2];

    always_ff @(posedge CLOCK2_50) begin
        if (KEY) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fb_we     = 1'b0;
        w_fb_waddr  = w_dw_idx;
        w_fb_wdata  = bus.RD2[7:0];
        w_addres    = bus.ALUResult;

        case (r_state)
            RUN: begin
                // A store in the same cycle as END still lands.
                w_fb_we = bus.MemWrite && w_in_win;
                if (bus.END) begin
                    w_state_nxt = COPY;
                    w_cnt_nxt   = '0;
                end
            end
            COPY: begin
                w_addres   = MEM_BASE + {17'd0, r_cnt, 2'b00};
                w_fb_we    = 1'b1;
                w_fb_waddr = r_cnt;
                w_fb_wdata = bus.ReadData[7:0];
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 13'd1;
                end
            end
            DONE: begin
                // Hold; stores and END are ignored until reset.
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign bus.ADDRES = w_addres;

    // Framebuffer write port. Contents survive reset; a reset cycle simply
    // suppresses the write so an aborted copy leaves no partial cell behind.
    always_ff @(posedge CLOCK2_50) begin
        if (w_fb_we && !KEY) begin
            r_fb[w_fb_waddr] <= w_fb_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Pixel timing
    // -----------------------------------------------------------------------
    logic       r_pix_en;
    logic [9:0] r_h, r_v;

    always_ff @(posedge CLOCK2_50) begin
        if (KEY) begin
            r_pix_en <= 1'b0;
            r_h      <= '0;
            r_v      <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scan-out: decode the current counter position, register everything on
    // the pixel enable so syncs, blank and colour stay aligned.
    // -----------------------------------------------------------------------
    logic        w_vis, w_hs_act, w_vs_act, w_border;
    logic [12:0] w_rd_idx;
    logic [7:0]  w_cell;

    assign w_vis    = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs_act = (r_h >= H_SYNC0) && (r_h <= H_SYNC1);
    assign w_vs_act = (r_v >= V_SYNC0) && (r_v <= V_SYNC1);

    // Index held at 0 during blanking so the read never leaves the array.
    assign w_rd_idx = w_vis ? (13'(r_v[9:3]) * 13'd80 + 13'(r_h[9:3])) : 13'd0;
    assign w_cell   = r_fb[w_rd_idx];

`ifdef PROYECTO_BORDER_EN
    assign w_border = (r_h == 10'd0) || (r_h == 10'd639) ||
                      (r_v == 10'd0) || (r_v == 10'd479);
`else
    assign w_border = 1'b0;
`endif

    logic       r_hs, r_vs, r_blank_n;
    logic [7:0] r_r, r_g, r_b;

    always_ff @(posedge CLOCK2_50) begin
        if (KEY) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else if (r_pix_en) begin
            r_hs      <= ~w_hs_act;
            r_vs      <= ~w_vs_act;
            r_blank_n <= w_vis;
            if (!w_vis) begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end else if (w_border) begin
                r_r <= 8'hFF;
                r_g <= 8'hFF;
                r_b <= 8'hFF;
            end else begin
                // Replicate the RGB332 fields so full-scale maps to 8'hFF.
                r_r <= {w_cell[7:5], w_cell[7:5], w_cell[7:6]};
                r_g <= {w_cell[4:2], w_cell[4:2], w_cell[4:3]};
                r_b <= {4{w_cell[1:0]}};
            end
        end
    end

    assign VGA_CLK     = r_pix_en;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;

    // Upper data bits and sub-word offset bits are not needed by this block.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.RD2[31:8], bus.ReadData[31:8],
                             w_dw_off[31:15], w_dw_off[1:0]};

endmodule

// File: tb/tb_proyecto.sv
// ---------------------------------------------------------------------------
// tb_proyecto -- directed/random bench for proyecto.
// Reference: a byte-array framebuffer model plus a word-array data memory;
// the expected pixel at (h,v) is derived from the cell formula and the
// timing rule "pixel p is shown from clock 2p+2 after reset".
// ---------------------------------------------------------------------------
module tb_proyecto;

    logic       CLOCK2_50 = 1'b0;
    logic       KEY;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_SYNC_N, VGA_BLANK_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    proyecto_if bus ();

    proyecto #(.MEM_BASE(32'h0000_1000), .FB_BASE(32'h0000_2000)) dut (
        .CLOCK2_50  (CLOCK2_50),
        .KEY        (KEY),
        .bus        (bus),
        .VGA_CLK    (VGA_CLK),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    always #10 CLOCK2_50 = ~CLOCK2_50;

    // Reference state
    logic [7:0]  fb_model [0:4799];
    logic [31:0] mem      [0:4799];
    logic [31:0] rd_idx;
    int          k;          // clocks since the last reset edge
    int          n_cmp = 0;
    int          n_bad = 0;

    // Data memory: same-cycle read of the word at ADDRES.
    always_comb begin
        rd_idx = (bus.ADDRES - 32'h1000) >> 2;
        if (bus.ADDRES >= 32'h1000 && bus.ADDRES <= 32'h5AFC)
            bus.ReadData = mem[rd_idx[12:0]];
        else
            bus.ReadData = 32'hDEAD_BEEF;
    end

    always @(posedge CLOCK2_50) k <= KEY ? 0 : k + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_px(input int h, input int v);
        logic [7:0]  c;
        logic [23:0] rgb;
        logic        vis;
        vis = (h < 640) && (v < 480);
        c   = vis ? fb_model[(v / 8) * 80 + h / 8] : 8'h00;
        rgb = {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
`ifdef PROYECTO_BORDER_EN
        if (h == 0 || h == 639 || v == 0 || v == 479) rgb = 24'hFFFFFF;
`endif
        if (!vis) rgb = 24'h0;
        return {5'd0, !(h >= 656 && h <= 751), !(v >= 490 && v <= 491), vis, rgb};
    endfunction

    function automatic logic [31:0] obs_px();
        return {5'd0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
    endfunction

    // Advance to the negedge where pixel (h,v) of the first frame is shown.
    task automatic goto_px(input int h, input int v);
        int target;
        target = 2 * (v * 800 + h) + 2;
        while (k < target) @(negedge CLOCK2_50);
        n_cmp++;
        if (k != target) begin
            n_bad++;
            $display("FAIL goto: clock %0d past target %0d", k, target);
        end
    endtask

    task automatic check_px(input int h, input int v);
        goto_px(h, v);
        chk($sformatf("px h=%0d v=%0d", h, v), obs_px(), exp_px(h, v));
    endtask

    task automatic do_reset();
        @(negedge CLOCK2_50);
        KEY = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.END       = 1'b0;
        bus.ALUResult = $urandom;
        repeat (2) @(posedge CLOCK2_50);
        @(negedge CLOCK2_50);
        chk("rst_outs", {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B},
            {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
        chk("rst_addres", bus.ADDRES, bus.ALUResult);
        KEY = 1'b0;
    endtask

    task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
        bus.ALUResult = addr;
        bus.RD2       = data;
        bus.MemWrite  = 1'b1;
        #1;
        chk("store_addres", bus.ADDRES, addr);
        @(negedge CLOCK2_50);
        bus.MemWrite  = 1'b0;
    endtask

    initial begin
        int idx, h, cnt_lo, cnt_hi, n;
        logic [31:0] d;
        logic [31:0] oow [4];

        KEY = 1'b1;
        bus.ALUResult = '0;
        bus.RD2       = '0;
        bus.MemWrite  = 1'b0;
        bus.END       = 1'b0;
        for (int i = 0; i < 4800; i++) mem[i] = $urandom;
        mem[81] = 32'h0000_0003;

        // ---- reset, then direct writes in RUN ----
        do_reset();
        cpu_store(32'h2000, 32'h0000_00E0);
        fb_model[0] = 8'hE0;
        for (int i = 1; i < 240; i++) begin
            d = $urandom;
            cpu_store(32'h2000 + 4 * i, d);
            fb_model[i] = d[7:0];
        end
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(239, 1);
            d   = $urandom;
            cpu_store(32'h2000 + 4 * idx + $urandom_range(3, 0), d);
            fb_model[idx] = d[7:0];
        end
        // Addresses outside the window must leave every cell untouched.
        oow[0] = 32'h0000_1000; oow[1] = 32'h0000_A000;
        oow[2] = 32'hFFFF_A000; oow[3] = 32'h0000_6B00;
        for (int i = 0; i < 4; i++) cpu_store(oow[i], $urandom);

        // ---- scan-out of the first lines ----
        do_reset();
        check_px(0, 0);   check_px(7, 0);   check_px(8, 0);   check_px(639, 0);
        check_px(640, 0); check_px(655, 0); check_px(656, 0); check_px(751, 0);
        check_px(752, 0); check_px(799, 0);

        n = 0;
        while (VGA_HS !== 1'b0 && n < 3000) begin @(negedge CLOCK2_50); n++; end
        cnt_lo = 0;
        while (VGA_HS === 1'b0 && cnt_lo < 400) begin @(negedge CLOCK2_50); cnt_lo++; end
        chk("hs_low_clocks", cnt_lo, 192);
        cnt_hi = 0;
        while (VGA_HS === 1'b1 && cnt_hi < 3000) begin @(negedge CLOCK2_50); cnt_hi++; end
        chk("line_clocks", cnt_lo + cnt_hi, 1600);

        for (int v = 3; v < 24; v++) begin
            h = (v == 7) ? 7 : $urandom_range(799, 0);
            check_px(h, v);
            if (v == 7) chk("cell0_red", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF_0000);
        end

        // ---- copy from data memory ----
        @(negedge CLOCK2_50);
        bus.END       = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.ALUResult = 32'h2000 + 4 * 5;
        bus.RD2       = $urandom;
        @(negedge CLOCK2_50);
        bus.END = 1'b0;
        for (int j = 0; j < 4800; j++) begin
            chk("copy_addr", bus.ADDRES, 32'h1000 + 4 * j);
            bus.MemWrite  = 1'b1;
            bus.ALUResult = 32'h2000 + 4 * $urandom_range(4799, 0);
            bus.RD2       = $urandom;
            @(negedge CLOCK2_50);
        end
        bus.MemWrite  = 1'b0;
        bus.ALUResult = $urandom;
        #1;
        chk("done_addres", bus.ADDRES, bus.ALUResult);
        cpu_store(32'h2000, 32'h0000_001C);   // ignored in DONE
        for (int i = 0; i < 4800; i++) fb_model[i] = mem[i][7:0];

        // ---- scan-out of copied data (framebuffer survives reset) ----
        do_reset();
        for (int v = 0; v < 16; v++) begin
            h = (v == 8) ? 8 : (v == 15) ? 15 : $urandom_range(799, 0);
            check_px(h, v);
            if (v == 8) chk("cell11_blue", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0000_00FF);
        end

        // ---- reset in the middle of a copy, then restart ----
        @(negedge CLOCK2_50);
        bus.END = 1'b1;
        @(negedge CLOCK2_50);
        bus.END = 1'b0;
        repeat (100) @(negedge CLOCK2_50);
        chk("copy_i100", bus.ADDRES, 32'h1000 + 4 * 100);
        KEY = 1'b1;
        bus.ALUResult = $urandom;
        @(negedge CLOCK2_50);
        KEY = 1'b0;
        chk("abort_run", bus.ADDRES, bus.ALUResult);
        bus.END = 1'b1;
        @(negedge CLOCK2_50);
        bus.END = 1'b0;
        chk("restart_i0", bus.ADDRES, 32'h1000);
        @(negedge CLOCK2_50);
        chk("restart_i1", bus.ADDRES, 32'h1004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
